// File: rtl/float_issue_pkg.sv
// Shared types for the float multiplier issue queue: operand job record and issue FSM states.
package float_issue_pkg;

    localparam int float_width   = 32;
    localparam int JOB_TAG_WIDTH = 4;

    typedef struct packed {
        logic [float_width-1:0]   a;
        logic [float_width-1:0]   b;
        logic [JOB_TAG_WIDTH-1:0] tag;
    } mul_job_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } mul_issue_state_t;

endpackage

// File: rtl/float_job_fifo.sv
// Synchronous FIFO of mul_job_t entries; DEPTH must be a power of two so the pointers wrap naturally.
module float_job_fifo
    import float_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  mul_job_t                   wdata,
    output mul_job_t                   rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    mul_job_t        mem_q [DEPTH];
    logic [PW-1:0]   wrPtr_q;
    logic [PW-1:0]   rdPtr_q;
    logic [CW-1:0]   count_q;
    logic            pushEn;
    logic            popEn;

    // Requests against a full or empty FIFO are dropped rather than corrupting the pointers.
    assign pushEn = push && !full;
    assign popEn  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushEn) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            count_q <= count_q + CW'(pushEn) - CW'(popEn);
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rdPtr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/float_mul_issue_queue.sv
// Feeds float_mul_pipeline one tagged job at a time and returns products in order.
// Optional watchdog on the multiplier ack is enabled by FLOAT_MUL_ISSUE_TIMEOUT_EN.
module float_mul_issue_queue
    import float_issue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = JOB_TAG_WIDTH,
    parameter int TIMEOUT   = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [float_width-1:0] in_a,
    input  logic [float_width-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   mul_req,
    output logic [float_width-1:0] mul_a,
    output logic [float_width-1:0] mul_b,
    input  logic                   mul_ack,
    input  logic [float_width-1:0] mul_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [float_width-1:0] res_out,
    output logic [TAG_WIDTH-1:0]   res_tag,
    output logic                   timeout_err
);

    localparam int CW = $clog2(DEPTH+1);

    mul_issue_state_t       state_q;
    mul_job_t               fifoWdata;
    mul_job_t               fifoRdata;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [CW-1:0]          fifoCount;
    logic [CW-1:0]          countNext;
    logic                   push;
    logic                   pop;
    logic                   inReady_q;
    logic                   inReady_d;
    logic                   mulReq_q;
    logic [float_width-1:0] jobA_q;
    logic [float_width-1:0] jobB_q;
    logic [TAG_WIDTH-1:0]   jobTag_q;
    logic                   resValid_q;
    logic [float_width-1:0] resOut_q;

    assign fifoWdata = '{a: in_a, b: in_b, tag: in_tag};
    assign push      = in_valid && inReady_q && !fifoFull;
    assign pop       = (state_q == IDLE) && !fifoEmpty;

    float_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (fifoWdata),
        .rdata (fifoRdata),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    // in_ready is registered from the next occupancy so it reads 0 throughout reset.
    assign countNext = fifoCount + CW'(push) - CW'(pop);
    assign inReady_d = (countNext != CW'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inReady_q <= 1'b0;
        end else begin
            inReady_q <= inReady_d;
        end
    end

`ifdef FLOAT_MUL_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);

    logic [TW-1:0] wdCnt_q;
    logic          timeoutErr_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mulReq_q   <= 1'b0;
            jobA_q     <= '0;
            jobB_q     <= '0;
            jobTag_q   <= '0;
            resValid_q <= 1'b0;
            resOut_q   <= '0;
`ifdef FLOAT_MUL_ISSUE_TIMEOUT_EN
            wdCnt_q      <= '0;
            timeoutErr_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifoEmpty) begin
                        jobA_q   <= fifoRdata.a;
                        jobB_q   <= fifoRdata.b;
                        jobTag_q <= fifoRdata.tag;
                        mulReq_q <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mulReq_q <= 1'b0;
                    state_q  <= WAIT;
`ifdef FLOAT_MUL_ISSUE_TIMEOUT_EN
                    wdCnt_q  <= '0;
`endif
                end
                WAIT: begin
                    if (mul_ack) begin
                        resOut_q   <= mul_out;
                        resValid_q <= 1'b1;
                        state_q    <= HOLD;
                    end
`ifdef FLOAT_MUL_ISSUE_TIMEOUT_EN
                    // Fires at the end of the TIMEOUT-th cycle spent waiting without an ack.
                    else if (wdCnt_q == TW'(TIMEOUT - 1)) begin
                        resOut_q     <= '0;
                        resValid_q   <= 1'b1;
                        timeoutErr_q <= 1'b1;
                        state_q      <= HOLD;
                    end else begin
                        wdCnt_q <= wdCnt_q + TW'(1);
                    end
`endif
                end
                HOLD: begin
                    if (res_ready) begin
                        resValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef FLOAT_MUL_ISSUE_TIMEOUT_EN
    assign timeout_err = timeoutErr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign in_ready  = inReady_q;
    assign mul_req   = mulReq_q;
    assign mul_a     = jobA_q;
    assign mul_b     = jobB_q;
    assign res_valid = resValid_q;
    assign res_out   = resOut_q;
    assign res_tag   = jobTag_q;

endmodule
